video_timing_gen: RTL

Parametrised video timing and test-pattern generator for the pixel-clock domain. It produces hsync, vsync and data-enable, and pixel coordinates with one of four selectable RGB test patterns. Timing is programmable at run time and takes effect only at frame boundaries. It replaces fixed-timing pattern generation so the same block drives 640x480 and other modes without resynthesis.

---
 rtl/video_timing_gen.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - programmable video timing and test-pattern generator
// Frame-boundary shadowed timing, registered sync/de/coordinates/colour outputs.
module video_timing_gen #(
  parameter int CW         = 12,
  parameter int H_TOTAL    = 799,
  parameter int H_SYNC     = 95,
  parameter int H_START    = 143,
  parameter int H_END      = 783,
  parameter int V_TOTAL    = 524,
  parameter int V_SYNC     = 1,
  parameter int V_START    = 34,
  parameter int V_END      = 514,
  parameter int HS_POL     = 0,
  parameter int VS_POL     = 0,
  parameter int BAR_SHIFT  = 7,
  parameter int GRID_SHIFT = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [CW-1:0] cfg_h_total,
  input  logic [CW-1:0] cfg_h_sync,
  input  logic [CW-1:0] cfg_h_start,
  input  logic [CW-1:0] cfg_h_end,
  input  logic [CW-1:0] cfg_v_total,
  input  logic [CW-1:0] cfg_v_sync,
  input  logic [CW-1:0] cfg_v_start,
  input  logic [CW-1:0] cfg_v_end,
  input  logic [1:0]    cfg_mode,
  input  logic [23:0]   cfg_solid,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          vga_de,
  output logic [7:0]    vga_r,
  output logic [7:0]    vga_g,
  output logic [7:0]    vga_b,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          frame_start,
  output logic          cfg_err
);

  typedef struct packed {
    logic [CW-1:0] h_total;
    logic [CW-1:0] h_sync;
    logic [CW-1:0] h_start;
    logic [CW-1:0] h_end;
    logic [CW-1:0] v_total;
    logic [CW-1:0] v_sync;
    logic [CW-1:0] v_start;
    logic [CW-1:0] v_end;
    logic [1:0]    mode;
    logic [23:0]   solid;
  } shadow_t;

  localparam shadow_t SHADOW_RST = '{
    h_total: CW'(H_TOTAL), h_sync: CW'(H_SYNC), h_start: CW'(H_START), h_end: CW'(H_END),
    v_total: CW'(V_TOTAL), v_sync: CW'(V_SYNC), v_start: CW'(V_START), v_end: CW'(V_END),
    mode: 2'd0, solid: 24'h000000
  };

  localparam logic HS_ON = HS_POL[0];
  localparam logic VS_ON = VS_POL[0];

  shadow_t       shadow_q, shadow_d;
  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;

  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          de_q, de_d;
  logic [7:0]    r_q, r_d;
  logic [7:0]    g_q, g_d;
  logic [7:0]    b_q, b_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          fs_q, fs_d;
  logic          err_q, err_d;

  logic          last_h;
  logic          frame_end;
  logic          h_act;
  logic          v_act;
  logic [CW-1:0] x_raw;
  logic [CW-1:0] y_raw;
  logic [CW-1:0] bar_full;
  logic [2:0]    bar_i;

  always_comb begin
    last_h    = (h_q == shadow_q.h_total);
    frame_end = last_h && (v_q == shadow_q.v_total);

    h_d = last_h ? '0 : h_q + CW'(1);
    v_d = v_q;
    if (last_h) begin
      v_d = (v_q == shadow_q.v_total) ? '0 : v_q + CW'(1);
    end

    // New settings are captured on the very last cycle so the next frame starts clean.
    shadow_d = shadow_q;
    if (frame_end) begin
      shadow_d = '{
        h_total: cfg_h_total, h_sync: cfg_h_sync, h_start: cfg_h_start, h_end: cfg_h_end,
        v_total: cfg_v_total, v_sync: cfg_v_sync, v_start: cfg_v_start, v_end: cfg_v_end,
        mode: cfg_mode, solid: cfg_solid
      };
    end
  end

  always_comb begin
    err_d = !((shadow_q.h_sync < shadow_q.h_start) && (shadow_q.h_start < shadow_q.h_end) &&
              (shadow_q.h_end <= shadow_q.h_total) &&
              (shadow_q.v_sync < shadow_q.v_start) && (shadow_q.v_start < shadow_q.v_end) &&
              (shadow_q.v_end <= shadow_q.v_total));

    h_act = (h_q > shadow_q.h_start) && (h_q <= shadow_q.h_end);
    v_act = (v_q > shadow_q.v_start) && (v_q <= shadow_q.v_end);
    de_d  = h_act && v_act && !err_d;

    hs_d = (h_q <= shadow_q.h_sync) ? HS_ON : ~HS_ON;
    vs_d = (v_q <= shadow_q.v_sync) ? VS_ON : ~VS_ON;
    fs_d = (h_q == '0) && (v_q == '0);

    x_raw = h_q - shadow_q.h_start - CW'(1);
    y_raw = v_q - shadow_q.v_start - CW'(1);
    x_d   = de_d ? x_raw : '0;
    y_d   = de_d ? y_raw : '0;

    // Bars past the eighth one repeat the last (white) bar.
    bar_full = x_raw >> BAR_SHIFT;
    bar_i    = (bar_full > CW'(7)) ? 3'd7 : bar_full[2:0];

    r_d = 8'h00;
    g_d = 8'h00;
    b_d = 8'h00;
    if (de_d) begin
      case (shadow_q.mode)
        2'd0: begin
          r_d = {8{bar_i[2]}};
          g_d = {8{bar_i[1]}};
          b_d = {8{bar_i[0]}};
        end
        2'd1: begin
          if ((x_raw[GRID_SHIFT-1:0] == '0) || (y_raw[GRID_SHIFT-1:0] == '0)) begin
            r_d = 8'hFF;
            g_d = 8'hFF;
            b_d = 8'hFF;
          end
        end
        2'd2: begin
          r_d = x_raw[7:0];
          g_d = x_raw[7:0];
          b_d = x_raw[7:0];
        end
        default: begin
          r_d = shadow_q.solid[23:16];
          g_d = shadow_q.solid[15:8];
          b_d = shadow_q.solid[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q      <= '0;
      v_q      <= '0;
      shadow_q <= SHADOW_RST;
      hs_q     <= ~HS_ON;
      vs_q     <= ~VS_ON;
      de_q     <= 1'b0;
      r_q      <= 8'h00;
      g_q      <= 8'h00;
      b_q      <= 8'h00;
      x_q      <= '0;
      y_q      <= '0;
      fs_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      shadow_q <= shadow_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      de_q     <= de_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
      x_q      <= x_d;
      y_q      <= y_d;
      fs_q     <= fs_d;
      err_q    <= err_d;
    end
  end

  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_de      = de_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign pix_x       = x_q;
  assign pix_y       = y_q;
  assign frame_start = fs_q;
  assign cfg_err     = err_q;

endmodule
